// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//
// Chain of STAGES pipeline registers, each WIDTH bits wide, with a valid bit
// per stage. Hazard logic steers the chain through per-stage stall (hold)
// and flush (kill) requests. Two saturating counters record the number of
// stalled cycles and the number of cycles that carry any flush.
//
// Ports
//   Clk          : clock, rising edge active
//   Rst          : asynchronous active-high reset
//   in_data      : stage-0 input word (fetch result)
//   in_valid     : in_data carries a real instruction
//   stall        : bit k asks stage k (and everything upstream) to hold
//   flush        : bit k turns stage k into a bubble
//   clr_cnt      : synchronous clear of both counters
//   in_ready     : stage 0 accepts in_data this cycle (PC write enable)
//   stage_data   : registered content of stage k at [k*WIDTH +: WIDTH]
//   stage_valid  : registered valid bit of every stage
//   stall_cycles : saturating count of cycles with in_ready low
//   flush_events : saturating count of cycles with any flush bit set
module pipe_reg_chain #(
   parameter int unsigned       WIDTH     = 32,
   parameter int unsigned       STAGES    = 4,
   parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         flush,
   input  logic                      clr_cnt,
   output logic                      in_ready,
   output logic [STAGES*WIDTH-1:0]   stage_data,
   output logic [STAGES-1:0]         stage_valid,
   output logic [CNT_W-1:0]          stall_cycles,
   output logic [CNT_W-1:0]          flush_events
);

   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;

   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_d;

   // hold[k] is set when stage k or any stage downstream of it stalls.
   logic [STAGES-1:0] hold;
   logic              hold_acc;

   // Walk from the last stage towards stage 0 with a running OR, so the
   // vector never depends on itself.
   always_comb begin
      hold     = '0;
      hold_acc = 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         hold_acc              = hold_acc | stall[STAGES-1-i];
         hold[STAGES-1-i]      = hold_acc;
      end
   end

   assign in_ready = ~hold[0];

   // Per-stage next state: flush, then hold, then bubble behind an
   // upstream stall, otherwise take the upstream content.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;

      if (flush[0]) begin
         data_d[0]  = NOP_VALUE;
         valid_d[0] = 1'b0;
      end else if (!hold[0]) begin
         data_d[0]  = in_data;
         valid_d[0] = in_valid;
      end

      for (int unsigned k = 1; k < STAGES; k++) begin
         if (flush[k]) begin
            data_d[k]  = NOP_VALUE;
            valid_d[k] = 1'b0;
         end else if (!hold[k]) begin
            if (stall[k-1]) begin
               data_d[k]  = NOP_VALUE;
               valid_d[k] = 1'b0;
            end else begin
               data_d[k]  = data_q[k-1];
               valid_d[k] = valid_q[k-1];
            end
         end
      end
   end

   // Counters: clear wins over increment; increment stops at all ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
      end else if (hold[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (clr_cnt) begin
         flush_cnt_d = '0;
      end else if ((|flush) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            data_q[k] <= NOP_VALUE;
         end
         valid_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      stage_data = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         stage_data[k*WIDTH +: WIDTH] = data_q[k];
      end
   end

   assign stage_valid  = valid_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;

endmodule
